// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts per-channel spikes over fixed windows, streams the
// per-window counts one channel per word, and reports the most active channel.
module spike_rate_decoder #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] spike_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              win_valid,
    output logic [CH_W-1:0]   win_ch,
    output logic              win_none,
    output logic              overrun,
    input  logic              clr_ovf
);

    localparam int unsigned WCNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [NUM_CH-1:0][CNT_W-1:0]  snap_q, snap_d;
    logic [CH_W-1:0]               ch_idx_q, ch_idx_d;
    logic                          out_valid_q, out_valid_d;
    logic [CH_W-1:0]               out_ch_q, out_ch_d;
    logic [CNT_W-1:0]              out_count_q, out_count_d;
    logic                          out_last_q, out_last_d;
    logic                          win_valid_q, win_valid_d;
    logic [CH_W-1:0]               win_ch_q, win_ch_d;
    logic                          win_none_q, win_none_d;
    logic                          ovf_q, ovf_d;
    logic                          ovf_set;
    logic                          win_end;
    logic                          hs;
    logic [CH_W-1:0]               best_idx;
    logic [CNT_W-1:0]              best_cnt;
    logic                          any_spike;

    assign win_end = en && (wcnt_q == WCNT_LAST);
    assign hs      = out_valid_q && out_ready;

    // Counts including this cycle's spikes, held at CNT_MAX once saturated
    always_comb begin
        cnt_inc = cnt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt_q[i] != CNT_MAX) begin
                cnt_inc[i] = cnt_q[i] + CNT_W'(spike_in[i]);
            end
        end
    end

    // Window position and running counts; both freeze while en is low
    always_comb begin
        wcnt_d = wcnt_q;
        cnt_d  = cnt_q;
        if (en) begin
            if (win_end) begin
                wcnt_d = '0;
                cnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                cnt_d  = cnt_inc;
            end
        end
    end

    // Argmax over the closing window; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx  = '0;
        best_cnt  = cnt_inc[0];
        any_spike = |cnt_inc;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (cnt_inc[i] > best_cnt) begin
                best_cnt = cnt_inc[i];
                best_idx = CH_W'(i);
            end
        end
    end

    // Serializer next state and registered output values
    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        snap_d      = snap_q;
        ovf_set     = 1'b0;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_ch_d    = '0;
        out_count_d = '0;
        out_last_d  = 1'b0;
        win_valid_d = win_end;
        win_ch_d    = win_ch_q;
        win_none_d  = win_none_q;

        case (state_q)
            S_IDLE: begin
                if (win_end) begin
                    state_d  = S_SEND;
                    snap_d   = cnt_inc;
                    ch_idx_d = '0;
                end
            end
            S_SEND: begin
                if (hs && out_last_q) begin
                    // Final word leaving on a window-end edge frees room for the new snapshot
                    ch_idx_d = '0;
                    if (win_end) begin
                        snap_d = cnt_inc;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (hs) begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                    if (win_end) begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        if (state_d == S_SEND) begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_idx_d;
            out_count_d = snap_d[ch_idx_d];
            out_last_d  = (ch_idx_d == CH_LAST);
        end

        if (win_end) begin
            win_ch_d   = any_spike ? best_idx : '0;
            win_none_d = !any_spike;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_ch_q    <= '0;
            win_none_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            ch_idx_q    <= ch_idx_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            win_valid_q <= win_valid_d;
            win_ch_q    <= win_ch_d;
            win_none_q  <= win_none_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign win_valid = win_valid_q;
    assign win_ch    = win_ch_q;
    assign win_none  = win_none_q;
    assign overrun   = ovf_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: WINDOW=16 main instance plus a
// CNT_W=4 instance sharing the same stimulus for saturation.
module tb_spike_rate_decoder;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SAT_W  = 4;
    localparam int unsigned WINDOW = 16;
    localparam int unsigned CH_W   = 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NUM_CH-1:0] spike_in;
    logic              out_ready;
    logic              clr_ovf;

    logic              out_valid, out_last, win_valid, win_none, overrun;
    logic [CH_W-1:0]   out_ch, win_ch;
    logic [CNT_W-1:0]  out_count;

    logic              s_out_valid, s_out_last, s_win_valid, s_win_none, s_overrun;
    logic [CH_W-1:0]   s_out_ch, s_win_ch;
    logic [SAT_W-1:0]  s_out_count;

    int n_checks;
    int n_fail;

    spike_rate_decoder #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW(WINDOW), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_count(out_count), .out_last(out_last), .win_valid(win_valid),
        .win_ch(win_ch), .win_none(win_none), .overrun(overrun), .clr_ovf(clr_ovf)
    );

    spike_rate_decoder #(
        .NUM_CH(NUM_CH), .CNT_W(SAT_W), .WINDOW(WINDOW), .CH_W(CH_W)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch),
        .out_count(s_out_count), .out_last(s_out_last), .win_valid(s_win_valid),
        .win_ch(s_win_ch), .win_none(s_win_none), .overrun(s_overrun), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int ch, input int cnt, input int last);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".ch"},    32'(out_ch),    ch);
        chk({tag, ".count"}, 32'(out_count), cnt);
        chk({tag, ".last"},  32'(out_last),  last);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic cyc(input logic e, input logic [3:0] s, input logic r, input logic c);
        en        = e;
        spike_in  = s;
        out_ready = r;
        clr_ovf   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},    32'(out_valid), 0);
        chk({tag, ".ch"},       32'(out_ch),    0);
        chk({tag, ".count"},    32'(out_count), 0);
        chk({tag, ".last"},     32'(out_last),  0);
        chk({tag, ".win_valid"}, 32'(win_valid), 0);
        chk({tag, ".win_ch"},   32'(win_ch),    0);
        chk({tag, ".win_none"}, 32'(win_none),  0);
        chk({tag, ".overrun"},  32'(overrun),   0);
    endtask

    initial begin
        logic [3:0] s;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        spike_in  = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst0");
        rst_n = 1'b1;

        // W1 (edges 1..16): ch0 every cycle, ch1 every other, ch2 never, ch3 once
        for (int k = 0; k < 16; k++) begin
            s = {(k == 5), 1'b0, (k % 2 == 0), 1'b1};
            cyc(1'b1, s, 1'b1, 1'b0);
            if (k == 14) chk("w1_no_early_valid", 32'(out_valid), 0);
        end
        chk_word("w1_w0", 0, 16, 0);
        chk("w1_win_valid", 32'(win_valid), 1);
        chk("w1_win_ch",    32'(win_ch),    0);
        chk("w1_win_none",  32'(win_none),  0);
        chk("sat_w1_valid", 32'(s_out_valid), 1);
        chk("sat_w1_ch",    32'(s_out_ch),    0);
        chk("sat_w1_count", 32'(s_out_count), 15);
        chk("sat_w1_last",  32'(s_out_last),  0);
        chk("sat_w1_winv",  32'(s_win_valid), 1);
        chk("sat_w1_winch", 32'(s_win_ch),    0);
        chk("sat_w1_winn",  32'(s_win_none),  0);
        chk("sat_w1_ovf",   32'(s_overrun),   0);

        // W2 (edges 17..32): ch2 continuous; W1 drains on the first edges
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 4'b0100, 1'b1, 1'b0);
            if (k == 0) begin
                chk_word("w1_w1", 1, 8, 0);
                chk("w1_win_pulse_end", 32'(win_valid), 0);
            end
            if (k == 1) chk_word("w1_w2", 2, 0, 0);
            if (k == 2) chk_word("w1_w3", 3, 1, 1);
            if (k == 3) chk("w1_drained", 32'(out_valid), 0);
        end
        chk_word("w2_w0", 0, 0, 0);
        chk("w2_win_ch", 32'(win_ch), 2);

        // W3: 5 enabled, 10 disabled with all spikes high, 11 enabled
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'b0100, 1'b1, 1'b0);
            if (k == 1) begin
                chk_word("w2_w2", 2, 16, 0);
                chk("sat_w2_ch",    32'(s_out_ch),    2);
                chk("sat_w2_count", 32'(s_out_count), 15);
            end
        end
        repeat (10) cyc(1'b0, 4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 11; k++) begin
            cyc(1'b1, 4'b0100, 1'b1, 1'b0);
            if (k == 0) chk("w3_not_at_undelayed_end", 32'(out_valid), 0);
            if (k == 9) chk("w3_not_before_end", 32'(out_valid), 0);
        end
        chk_word("w3_w0", 0, 0, 0);
        chk("w3_win_valid", 32'(win_valid), 1);
        chk("w3_win_ch",    32'(win_ch),    2);

        // W4 (edges 59..74): ch1=5, ch3=5, ch0=4 -> tie resolves to ch1
        for (int k = 0; k < 16; k++) begin
            s = {(k >= 5 && k < 10), 1'b0, (k < 5), (k >= 10 && k < 14)};
            cyc(1'b1, s, 1'b1, 1'b0);
            if (k == 1) begin
                chk_word("w3_w2", 2, 16, 0);
                chk("sat_w3_count", 32'(s_out_count), 15);
            end
        end
        chk_word("w4_w0", 0, 4, 0);
        chk("w4_win_ch",   32'(win_ch),   1);
        chk("w4_win_none", 32'(win_none), 0);

        // Stall 20 cycles: W5 (no spikes) ends mid-stall and is dropped
        for (int k = 0; k < 20; k++) begin
            s = (k >= 16) ? 4'b1000 : 4'b0000;
            cyc(1'b1, s, 1'b0, 1'b0);
            if (k == 5)  chk_word("stall_a", 0, 4, 0);
            if (k == 14) chk("ovf_before", 32'(overrun), 0);
            if (k == 15) begin
                chk("ovf_set",       32'(overrun),   1);
                chk("w5_win_valid",  32'(win_valid), 1);
                chk("w5_win_none",   32'(win_none),  1);
                chk("w5_win_ch",     32'(win_ch),    0);
                chk_word("stall_b", 0, 4, 0);
            end
            if (k == 19) chk_word("stall_c", 0, 4, 0);
        end

        // Release: only W4's words come out; clear overrun at edge 99
        for (int k = 0; k < 12; k++) begin
            s = (k < 3) ? 4'b1000 : 4'b0000;
            cyc(1'b1, s, 1'b1, (k == 4));
            if (k == 0) chk_word("w4_w1", 1, 5, 0);
            if (k == 1) chk_word("w4_w2", 2, 0, 0);
            if (k == 2) chk_word("w4_w3", 3, 5, 1);
            if (k == 3) begin
                chk("w5_dropped", 32'(out_valid), 0);
                chk("ovf_sticky", 32'(overrun),   1);
            end
            if (k == 4) chk("ovf_cleared", 32'(overrun), 0);
        end
        chk_word("w6_w0", 0, 0, 0);
        chk("w6_win_ch", 32'(win_ch), 3);

        // W7: stall 12 cycles, then last W6 handshake lands on W7's end edge
        for (int k = 0; k < 16; k++) begin
            s = (k < 3) ? 4'b0100 : 4'b0000;
            cyc(1'b1, s, (k >= 12), 1'b0);
            if (k == 11) chk_word("w6_held", 0, 0, 0);
            if (k == 14) chk_word("w6_w3", 3, 7, 1);
        end
        chk_word("w7_w0", 0, 0, 0);
        chk("coinc_no_ovf",  32'(overrun),   0);
        chk("w7_win_valid",  32'(win_valid), 1);
        chk("w7_win_ch",     32'(win_ch),    2);
        cyc(1'b1, 4'b0001, 1'b1, 1'b0);
        chk_word("w7_w1", 1, 0, 0);
        cyc(1'b1, 4'b0001, 1'b1, 1'b0);
        chk_word("w7_w2", 2, 3, 0);

        // Asynchronous reset mid-send; partial window must be discarded
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 4'b0001, 1'b1, 1'b0);
            if (k == 14) chk("post_rst_no_early_valid", 32'(out_valid), 0);
        end
        chk_word("post_rst_w0", 0, 16, 0);
        chk("sat_post_rst_count", 32'(s_out_count), 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
